// File: rtl/ula_pkg.sv
// Shared types and widths for the ULA serial flag generator and its neighbours.
package ula_pkg;

  localparam int ULA_IN_W  = 8;
  localparam int ULA_OUT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ula_serial_state_t;

endpackage

// File: rtl/ula_serial_flag_gen_if.sv
// Operand/flag handshake bundle for ula_serial_flag_gen.
// Optional macro ULA_SERIAL_DIFF_OUT_EN adds the sign/zero-extended difference.
interface ula_serial_flag_gen_if #(
  parameter int WIDTH = ula_pkg::ULA_IN_W
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic             zero_flag;
  logic             sign_flag;
  logic             carry_flag;
  logic             overflow_flag;
`ifdef ULA_SERIAL_DIFF_OUT_EN
  logic [ula_pkg::ULA_OUT_W-1:0] diff;
`endif

  modport master (
    output a, b, in_valid, out_ready,
    input  in_ready, out_valid, zero_flag, sign_flag, carry_flag, overflow_flag
`ifdef ULA_SERIAL_DIFF_OUT_EN
    , input diff
`endif
  );

  modport slave (
    input  a, b, in_valid, out_ready,
    output in_ready, out_valid, zero_flag, sign_flag, carry_flag, overflow_flag
`ifdef ULA_SERIAL_DIFF_OUT_EN
    , output diff
`endif
  );

endinterface

// File: rtl/ula_full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout = borrow out.
module ula_full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/ula_serial_flag_gen.sv
// Bit-serial A-B stage feeding the ULA comparator: one difference bit per
// clock, LSB first, then zero/sign/carry/overflow flags behind valid/ready.
// Optional macro ULA_SERIAL_DIFF_OUT_EN also registers the extended difference.
module ula_serial_flag_gen
  import ula_pkg::*;
#(
  parameter int WIDTH  = ULA_IN_W,  // operand width, >= 2
  parameter bit SIGNED = 1'b1       // 1: two's-complement compare, 0: unsigned
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ula_serial_flag_gen_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  ula_serial_state_t r_state;
  ula_serial_state_t w_state_next;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [CNT_W-1:0] r_count;
  logic             r_borrow;
  logic             r_nz_acc;
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_zero_flag;
  logic             r_sign_flag;
  logic             r_carry_flag;
  logic             r_overflow_flag;

  logic w_d;
  logic w_bout;
  logic w_last_bit;
  logic w_overflow;
  logic w_sign;
  logic w_in_ready;
  logic w_out_valid;

  // Single subtractor cell walks the operands from LSB to MSB.
  ula_full_subtractor u_fs (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bout)
  );

  assign w_last_bit = (r_count == CNT_W'(WIDTH - 1));

  // Flag values as they will be if this is the MSB cycle.
  always_comb begin
    w_overflow = (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_d);
    w_sign     = SIGNED ? (w_d ^ w_overflow) : w_bout;
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    // NOTE: all outputs get defaults before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_next = SHIFT;
      end
      SHIFT: begin
        if (w_last_bit) w_state_next = DONE;
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

`ifdef ULA_SERIAL_DIFF_OUT_EN
  logic [WIDTH-1:0]     w_diff_full;
  logic [ULA_OUT_W-1:0] w_diff_ext;
  logic [ULA_OUT_W-1:0] r_diff;

  // The vacated MSBs of a_sh collect difference bits, so on the MSB cycle
  // the complete difference is the current bit on top of a_sh[WIDTH-1:1].
  always_comb begin
    w_diff_full = {w_d, r_a_sh[WIDTH-1:1]};
    w_diff_ext  = SIGNED ? ULA_OUT_W'($signed(w_diff_full)) : ULA_OUT_W'(w_diff_full);
  end

  // Difference output register, updated together with the flags.
  always_ff @(posedge clk) begin
    if (!rst_n)                                r_diff <= '0;
    else if ((r_state == SHIFT) && w_last_bit) r_diff <= w_diff_ext;
  end

  assign bus.diff = r_diff;
`endif

  // Shift datapath and flag capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_sh          <= '0;
      r_b_sh          <= '0;
      r_count         <= '0;
      r_borrow        <= 1'b0;
      r_nz_acc        <= 1'b0;
      r_a_msb         <= 1'b0;
      r_b_msb         <= 1'b0;
      r_zero_flag     <= 1'b0;
      r_sign_flag     <= 1'b0;
      r_carry_flag    <= 1'b0;
      r_overflow_flag <= 1'b0;
    end else if ((r_state == IDLE) && bus.in_valid) begin
      r_a_sh   <= bus.a;
      r_b_sh   <= bus.b;
      r_count  <= '0;
      r_borrow <= 1'b0;
      r_nz_acc <= 1'b0;
      r_a_msb  <= bus.a[WIDTH-1];
      r_b_msb  <= bus.b[WIDTH-1];
    end else if (r_state == SHIFT) begin
      r_a_sh   <= {w_d, r_a_sh[WIDTH-1:1]};
      r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
      r_borrow <= w_bout;
      r_nz_acc <= r_nz_acc | w_d;
      r_count  <= r_count + 1'b1;
      if (w_last_bit) begin
        r_zero_flag     <= ~(r_nz_acc | w_d);
        r_carry_flag    <= w_bout;
        r_overflow_flag <= w_overflow;
        r_sign_flag     <= w_sign;
      end
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = w_out_valid;
  assign bus.zero_flag     = r_zero_flag;
  assign bus.sign_flag     = r_sign_flag;
  assign bus.carry_flag    = r_carry_flag;
  assign bus.overflow_flag = r_overflow_flag;

endmodule

// File: tb/tb_ula_serial_flag_gen.sv
// Scoreboard bench for ula_serial_flag_gen: a signed and an unsigned instance
// run the same directed vectors in lock-step; monitors pop expected flags on
// every output handshake. Honours ULA_SERIAL_DIFF_OUT_EN for the diff port.
module tb_ula_serial_flag_gen;
  import ula_pkg::*;

  localparam int W = ULA_IN_W;

  typedef struct packed {
    logic [3:0]           flags;  // {zero, sign, carry, overflow}
    logic [ULA_OUT_W-1:0] diff;
  } exp_t;

  typedef struct packed {
    logic [W-1:0]         a;
    logic [W-1:0]         b;
    logic [3:0]           fs;     // expected flags, SIGNED=1
    logic [3:0]           fu;     // expected flags, SIGNED=0
    logic [ULA_OUT_W-1:0] ds;     // expected diff, SIGNED=1
    logic [ULA_OUT_W-1:0] du;     // expected diff, SIGNED=0
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [W-1:0] drv_a;
  logic [W-1:0] drv_b;
  logic         drv_in_valid;
  logic         drv_out_ready;

  ula_serial_flag_gen_if #(.WIDTH(W)) if_s ();
  ula_serial_flag_gen_if #(.WIDTH(W)) if_u ();

  assign if_s.a         = drv_a;
  assign if_s.b         = drv_b;
  assign if_s.in_valid  = drv_in_valid;
  assign if_s.out_ready = drv_out_ready;
  assign if_u.a         = drv_a;
  assign if_u.b         = drv_b;
  assign if_u.in_valid  = drv_in_valid;
  assign if_u.out_ready = drv_out_ready;

  ula_serial_flag_gen #(.WIDTH(W), .SIGNED(1'b1)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_s)
  );

  ula_serial_flag_gen #(.WIDTH(W), .SIGNED(1'b0)) dut_u (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_u)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t q_s[$];
  exp_t q_u[$];
  vec_t vecs [0:7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] flags_s();
    return {if_s.zero_flag, if_s.sign_flag, if_s.carry_flag, if_s.overflow_flag};
  endfunction

  function automatic logic [3:0] flags_u();
    return {if_u.zero_flag, if_u.sign_flag, if_u.carry_flag, if_u.overflow_flag};
  endfunction

  // Monitor: compare against the scoreboard on every signed-instance handshake.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && if_s.out_valid && if_s.out_ready) begin
      if (q_s.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sgn_unexpected_out: got out_valid=1, required no output");
      end else begin
        exp_t e;
        e = q_s.pop_front();
        check("sgn_flags", 32'(flags_s()), 32'(e.flags));
`ifdef ULA_SERIAL_DIFF_OUT_EN
        check("sgn_diff", 32'(if_s.diff), 32'(e.diff));
`endif
      end
    end
  end

  // Monitor: same for the unsigned instance.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && if_u.out_valid && if_u.out_ready) begin
      if (q_u.size() == 0) begin
        total++;
        bad++;
        $display("FAIL uns_unexpected_out: got out_valid=1, required no output");
      end else begin
        exp_t e;
        e = q_u.pop_front();
        check("uns_flags", 32'(flags_u()), 32'(e.flags));
`ifdef ULA_SERIAL_DIFF_OUT_EN
        check("uns_diff", 32'(if_u.diff), 32'(e.diff));
`endif
      end
    end
  end

  // One transaction on both instances; stall holds out_ready low for 5 DONE cycles.
  task automatic run_vec(input vec_t v, input bit stall);
    int lat;
    check("in_ready_idle", 32'({if_s.in_ready, if_u.in_ready}), 32'(2'b11));
    drv_a         = v.a;
    drv_b         = v.b;
    drv_in_valid  = 1'b1;
    drv_out_ready = !stall;
    q_s.push_back('{flags: v.fs, diff: v.ds});
    q_u.push_back('{flags: v.fu, diff: v.du});
    tick();                                   // accept edge
    drv_in_valid = 1'b0;
    drv_a        = ~v.a;                      // must not disturb the in-flight op
    drv_b        = ~v.b;
    check("in_ready_busy", 32'({if_s.in_ready, if_u.in_ready}), 32'(2'b00));
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!if_s.out_valid && lat < 3 * W);
    check("latency", 32'(lat), 32'(W));
    check("out_valid_both", 32'({if_s.out_valid, if_u.out_valid}), 32'(2'b11));
    if (stall) begin
      for (int i = 0; i < 5; i++) begin
        drv_in_valid = 1'b1;
        drv_a        = 8'h55;
        drv_b        = 8'h66;
        check("stall_out_valid", 32'({if_s.out_valid, if_u.out_valid}), 32'(2'b11));
        check("stall_in_ready", 32'({if_s.in_ready, if_u.in_ready}), 32'(2'b00));
        check("stall_flags_sgn", 32'(flags_s()), 32'(v.fs));
        check("stall_flags_uns", 32'(flags_u()), 32'(v.fu));
        tick();
      end
      drv_in_valid  = 1'b0;
      drv_out_ready = 1'b1;
    end
    tick();                                   // handshake edge
    check("one_cycle_valid", 32'({if_s.out_valid, if_u.out_valid}), 32'(2'b00));
    check("back_to_idle", 32'({if_s.in_ready, if_u.in_ready}), 32'(2'b11));
    check("flags_held_sgn", 32'(flags_s()), 32'(v.fs));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    //           a      b      fs       fu       ds        du
    vecs[0] = '{8'h5A, 8'h5A, 4'b1000, 4'b1000, 16'h0000, 16'h0000};
    vecs[1] = '{8'hFE, 8'h03, 4'b0100, 4'b0000, 16'hFFFB, 16'h00FB};
    vecs[2] = '{8'h80, 8'h01, 4'b0101, 4'b0001, 16'h007F, 16'h007F};
    vecs[3] = '{8'h02, 8'hF0, 4'b0010, 4'b0110, 16'h0012, 16'h0012};
    vecs[4] = '{8'h10, 8'h01, 4'b0000, 4'b0000, 16'h000F, 16'h000F};
    vecs[5] = '{8'h00, 8'h00, 4'b1000, 4'b1000, 16'h0000, 16'h0000};
    vecs[6] = '{8'h7F, 8'hFF, 4'b0011, 4'b0111, 16'hFF80, 16'h0080};
    vecs[7] = '{8'h01, 8'h02, 4'b0110, 4'b0110, 16'hFFFF, 16'h00FF};

    rst_n         = 1'b0;
    drv_a         = '0;
    drv_b         = '0;
    drv_in_valid  = 1'b0;
    drv_out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 32'({if_s.in_ready, if_u.in_ready}), 32'(2'b11));
    check("rst_out_valid", 32'({if_s.out_valid, if_u.out_valid}), 32'(2'b00));
    check("rst_flags_sgn", 32'(flags_s()), 32'(4'b0000));
    check("rst_flags_uns", 32'(flags_u()), 32'(4'b0000));
`ifdef ULA_SERIAL_DIFF_OUT_EN
    check("rst_diff", 32'({if_s.diff, if_u.diff}), 32'(0));
`endif
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i == 4);

    // Reset in the middle of SHIFT must discard the operation.
    drv_a         = 8'h12;
    drv_b         = 8'h34;
    drv_in_valid  = 1'b1;
    drv_out_ready = 1'b1;
    tick();                                   // accept, cycle 0
    drv_in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();                                   // reset edge, cycle 3
    check("midrst_in_ready", 32'({if_s.in_ready, if_u.in_ready}), 32'(2'b11));
    check("midrst_out_valid", 32'({if_s.out_valid, if_u.out_valid}), 32'(2'b00));
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 2 * W; i++) begin
      tick();
      seen |= if_s.out_valid | if_u.out_valid;
    end
    check("midrst_no_output", 32'(seen), 32'(0));

    check("sgn_queue_empty", 32'(q_s.size()), 32'(0));
    check("uns_queue_empty", 32'(q_u.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
